// File: rtl/sha256_sched_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_sched_ctrl
//
// Sequencer for one SHA-256 compression of a 512-bit message block. It owns
// the round counter and the sliding 16-word message-schedule window. Each
// round it presents the schedule word W_t, the round constant K_t and a
// round strobe to the compression datapath. It sits between the nonce/block
// builder and the compression core in the miner pipeline.
//
// Ports:
//   clk        in   1    system clock, all state changes on the rising edge
//   rst        in   1    synchronous active-high reset
//   start      in   1    request to process block_in (looked at only in IDLE)
//   block_in   in   512  message block, big-endian words, W0 in [511:480]
//   hold       in   1    datapath stall request (looked at only in ROUND)
//   busy       out  1    high while rounds are being sequenced
//   init_state out  1    pulse in the cycle a start is accepted; the core
//                        loads its a..h working registers
//   round_en   out  1    w_t / k_t / round_idx are valid for the core
//   round_idx  out  6    current round number t
//   w_t        out  32   schedule word W_t
//   k_t        out  32   round constant K_t
//   done       out  1    one-cycle pulse after the final round
//
// Parameters:
//   ROUNDS     number of rounds per block, legal range 17..64
// ---------------------------------------------------------------------------
module sha256_sched_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic         hold,
    output logic         busy,
    output logic         init_state,
    output logic         round_en,
    output logic [5:0]   round_idx,
    output logic [31:0]  w_t,
    output logic [31:0]  k_t,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    // SHA-256 round constants: first 32 bits of the fractional parts of the
    // cube roots of the first 64 primes.
    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Small sigma functions of the message schedule. The rotates are
    // written as bit concatenations so they cost only wiring.
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  roundIdx_q, roundIdx_d;
    logic [31:0] window_q [16];
    logic [31:0] window_d [16];
    logic [31:0] nextWord;

    // The next schedule word, W_{t+16}, built from the current window where
    // window[0] holds W_t. Additions wrap modulo 2^32.
    always_comb begin
        nextWord = sigma1(window_q[14]) + window_q[9]
                 + sigma0(window_q[1]) + window_q[0];
    end

    // Next-state and output logic. The window shifts down one word per
    // un-stalled round, so the word the core needs is always in slot 0 and
    // only the newest slot needs the schedule adder.
    always_comb begin
        state_d    = state_q;
        roundIdx_d = roundIdx_q;
        window_d   = window_q;
        busy       = 1'b0;
        init_state = 1'b0;
        round_en   = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 16; i++) begin
                        window_d[i] = block_in[511 - 32*i -: 32];
                    end
                    roundIdx_d = 6'd0;
                    init_state = 1'b1;
                    state_d    = ROUND;
                end
            end

            ROUND: begin
                busy = 1'b1;
                if (!hold) begin
                    round_en = 1'b1;
                    for (int i = 0; i < 15; i++) begin
                        window_d[i] = window_q[i + 1];
                    end
                    window_d[15] = nextWord;
                    if (roundIdx_q == LAST_ROUND) begin
                        roundIdx_d = 6'd0;
                        state_d    = DONE;
                    end else begin
                        roundIdx_d = roundIdx_q + 6'd1;
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d    = IDLE;
                roundIdx_d = 6'd0;
            end
        endcase
    end

    // State, counter and window registers. Reset clears everything so an
    // aborted block leaves no trace and produces no done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            roundIdx_q <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                window_q[i] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            roundIdx_q <= roundIdx_d;
            for (int i = 0; i < 16; i++) begin
                window_q[i] <= window_d[i];
            end
        end
    end

    // Datapath-facing outputs come straight from the registers.
    always_comb begin
        round_idx = roundIdx_q;
        w_t       = window_q[0];
        k_t       = K_ROM[roundIdx_q];
    end

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha256_sched_ctrl
//
// Scoreboard bench for sha256_sched_ctrl. The stimulus process pushes the
// expected round sequence of every block it starts (computed from the
// textbook SHA-256 schedule recurrence over a 64-entry array) and an
// expected done marker. A monitor process samples on the falling edge and
// pops one entry for every round_en or done it sees.
// ---------------------------------------------------------------------------
module tb_sha256_sched_ctrl;

    localparam int ROUNDS = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         hold = 1'b0;
    logic [511:0] block_in = '0;
    logic         busy;
    logic         init_state;
    logic         round_en;
    logic [5:0]   round_idx;
    logic [31:0]  w_t;
    logic [31:0]  k_t;
    logic         done;

    typedef struct {
        bit          isDone;
        int          idx;
        logic [31:0] w;
        logic [31:0] k;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   initSeen   = 0;
    bit   abcMode    = 1'b0;

    logic [31:0] kTab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_sched_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .block_in   (block_in),
        .hold       (hold),
        .busy       (busy),
        .init_state (init_state),
        .round_en   (round_en),
        .round_idx  (round_idx),
        .w_t        (w_t),
        .k_t        (k_t),
        .done       (done)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    // Hard time limit so a stuck run still ends with a report.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [511:0] randomBlock();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) begin
            b[32*i +: 32] = $urandom;
        end
        return b;
    endfunction

    // Reference model: full 64-word schedule from the standard recurrence,
    // queued as the rounds the core should see, optionally followed by done.
    task automatic pushSchedule(input logic [511:0] blk, input int lastT, input bit withDone);
        logic [31:0] w [64];
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            w[i] = blk[511 - 32*i -: 32];
        end
        for (int i = 16; i < 64; i++) begin
            w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
        end
        for (int t = 0; t <= lastT; t++) begin
            e.isDone = 1'b0;
            e.idx    = t;
            e.w      = w[t];
            e.k      = kTab[t];
            expQ.push_back(e);
        end
        if (withDone) begin
            e.isDone = 1'b1;
            e.idx    = 0;
            e.w      = '0;
            e.k      = '0;
            expQ.push_back(e);
        end
    endtask

    // Monitor: samples on the falling edge, where the inputs driven after
    // the previous rising edge and the registered state are consistent.
    always @(negedge clk) begin
        exp_t e;
        if (init_state) initSeen++;
        if (busy && hold) checkOutput("round_en_during_hold", {31'd0, round_en}, 32'd0);
        if (round_en) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_round: got round %0d, expected no round", round_idx);
            end else begin
                e = expQ.pop_front();
                if (e.isDone) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL round_vs_done: got round %0d, expected done", round_idx);
                end else begin
                    checkOutput("round_idx", {26'd0, round_idx}, e.idx);
                    checkOutput($sformatf("w_t[%0d]", e.idx), w_t, e.w);
                    checkOutput($sformatf("k_t[%0d]", e.idx), k_t, e.k);
                    if (abcMode) begin
                        if (e.idx == 0) begin
                            checkOutput("abc_w0", w_t, 32'h61626380);
                            checkOutput("abc_k0", k_t, 32'h428a2f98);
                        end
                        if (e.idx == 16) checkOutput("abc_w16", w_t, 32'h61626380);
                        if (e.idx == 17) checkOutput("abc_w17", w_t, 32'h000F0000);
                        if (e.idx == 63) checkOutput("abc_k63", k_t, 32'hc67178f2);
                    end
                end
            end
        end
        if (done) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_done: got done 1, expected 0");
            end else begin
                e = expQ.pop_front();
                if (!e.isDone) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL early_done: got done, expected round %0d", e.idx);
                end
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one block. Stalls are placed at model round numbers; a second
    // start can be fired mid-block, and reset can abort the block at round
    // resetAt. randHold sprinkles random single-cycle stalls.
    task automatic applyStimulus(input logic [511:0] blk,
                                 input int h1T, input int h1Len,
                                 input int h2T, input int h2Len,
                                 input int busyStartAt, input int resetAt,
                                 input bit randHold);
        int t;
        int used1;
        int used2;
        int initBefore;
        bit holdNow;
        bit rstNow;
        initBefore = initSeen;
        pushSchedule(blk, (resetAt >= 0) ? resetAt : ROUNDS - 1, resetAt < 0);
        start    = 1'b1;
        block_in = blk;
        stepCycle();
        start    = 1'b0;
        block_in = randomBlock();
        t = 0; used1 = 0; used2 = 0; rstNow = 1'b0;
        while (t < ROUNDS) begin
            holdNow = 1'b0;
            if (t == h1T && used1 < h1Len) begin
                holdNow = 1'b1;
                used1++;
            end else if (t == h2T && used2 < h2Len) begin
                holdNow = 1'b1;
                used2++;
            end else if (randHold && $urandom_range(0, 3) == 0) begin
                holdNow = 1'b1;
            end
            hold   = holdNow;
            start  = (t == busyStartAt);
            if (start) block_in = randomBlock();
            rstNow = (t == resetAt) && !holdNow;
            rst    = rstNow;
            stepCycle();
            start = 1'b0;
            hold  = 1'b0;
            rst   = 1'b0;
            if (rstNow) break;
            if (!holdNow) t++;
        end
        if (rstNow) begin
            @(negedge clk);
            checkOutput("busy_after_reset", {31'd0, busy}, 32'd0);
            checkOutput("round_idx_after_reset", {26'd0, round_idx}, 32'd0);
            checkOutput("done_after_reset", {31'd0, done}, 32'd0);
            for (int i = 0; i < 3; i++) stepCycle();
            checkOutput("queue_left_after_reset", expQ.size(), 32'd0);
            checkOutput("init_count", initSeen - initBefore, 32'd1);
        end else begin
            @(negedge clk);
            checkOutput("done_on_time", {31'd0, done}, 32'd1);
            checkOutput("busy_in_done", {31'd0, busy}, 32'd0);
            checkOutput("round_en_in_done", {31'd0, round_en}, 32'd0);
            start    = 1'b1;
            block_in = randomBlock();
            stepCycle();
            start = 1'b0;
            @(negedge clk);
            checkOutput("done_single_cycle", {31'd0, done}, 32'd0);
            checkOutput("start_in_done_ignored", {31'd0, busy}, 32'd0);
            checkOutput("init_count", initSeen - initBefore, 32'd1);
            checkOutput("queue_left", expQ.size(), 32'd0);
            stepCycle();
        end
    endtask

    initial begin
        logic [511:0] abcBlk;
        abcBlk = {32'h61626380, 448'd0, 32'h00000018};

        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle_busy", {31'd0, busy}, 32'd0);
            checkOutput("idle_done", {31'd0, done}, 32'd0);
            checkOutput("idle_round_en", {31'd0, round_en}, 32'd0);
            checkOutput("idle_init_state", {31'd0, init_state}, 32'd0);
            checkOutput("idle_round_idx", {26'd0, round_idx}, 32'd0);
            stepCycle();
        end

        abcMode = 1'b1;
        $display("[TB] abc block, no stalls");
        applyStimulus(abcBlk, -1, 0, -1, 0, -1, -1, 1'b0);
        $display("[TB] abc block, stalls at t=10 (3) and t=63 (1)");
        applyStimulus(abcBlk, 10, 3, 63, 1, -1, -1, 1'b0);
        $display("[TB] abc block, second start at t=20");
        applyStimulus(abcBlk, -1, 0, -1, 0, 20, -1, 1'b0);
        $display("[TB] abc block, reset at t=30");
        applyStimulus(abcBlk, -1, 0, -1, 0, -1, 30, 1'b0);
        $display("[TB] abc block after reset");
        applyStimulus(abcBlk, -1, 0, -1, 0, -1, -1, 1'b0);
        abcMode = 1'b0;

        for (int n = 0; n < 4; n++) begin
            $display("[TB] random block %0d with random stalls", n);
            applyStimulus(randomBlock(), -1, 0, -1, 0,
                          $urandom_range(0, 70), -1, 1'b1);
        end

        checkOutput("final_queue_empty", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sha256_sched_ctrl.md
Name: sha256_sched_ctrl

Overview:
- Sequences one SHA-256 compression of a 512-bit block.
- Owns the round counter and the 16-word message-schedule window, and generates W_t using the small sigma functions σ0 and σ1.
- Supplies W_t, K_t and round strobes to the round datapath, with start/busy/done handshake and a hold input for stalls.
- Sits between the nonce/block builder and the compression core in the miner pipeline.

Parameters:
- ROUNDS, 64, number of rounds per block. Legal range 17..64. The K ROM is indexed by round_idx.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to process block_in. Sampled only in IDLE.
- block_in  in  512  message block, big-endian words. W0 = block_in[511:480], W15 = block_in[31:0].
- hold  in  1  stall request from the datapath. Honoured only in ROUND.
- busy  out  1  high in ROUND.
- init_state  out  1  one-cycle pulse on the cycle start is accepted; tells the core to load its a..h working registers.
- round_en  out  1  high when w_t/k_t/round_idx are valid for the core this cycle.
- round_idx  out  6  current round t.
- w_t  out  32  schedule word W_t.
- k_t  out  32  round constant K_t.
- done  out  1  one-cycle pulse after the last round completes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, round_idx=0, window cleared to 0.
  - busy=0, init_state=0, round_en=0, done=0.
  - Reset mid-ROUND aborts the block; no done pulse is produced.
- States: IDLE, ROUND, DONE.
- IDLE:
  - If start=1: capture block_in into window[0..15], round_idx<=0, state<=ROUND, init_state=1 (combinational in that cycle).
  - Otherwise hold.
- ROUND:
  - busy=1, w_t=window[0], k_t=K[round_idx].
  - round_en = ~hold.
  - If hold=1: window and round_idx frozen, round_en=0.
  - If hold=0, at the edge:
    - window shifts down one: window[i] <= window[i+1].
    - window[15] <= σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32.
    - round_idx <= round_idx+1.
  - When round_idx = ROUNDS-1 and hold=0: state<=DONE, round_idx<=0.
- Sigma functions:
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- DONE: done=1 for exactly one cycle, busy=0, round_en=0; state<=IDLE next edge.
- Outputs w_t and k_t are don't-care when round_en=0. Bench checks them only on round_en=1.
- start while busy or in DONE is ignored; no queuing. A start in the cycle after done is accepted.
- Latency:
  - start accepted at edge E; rounds present on cycles E+1 .. E+ROUNDS when hold stays low.
  - done asserted on cycle E+ROUNDS+1.
  - Each hold cycle adds one cycle.
- hold asserted on the final round delays the transition to DONE until hold deasserts.
- Counter: round_idx never exceeds ROUNDS-1; it wraps to 0 only via DONE/IDLE.
- All additions are 32-bit, with carries discarded.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 10 idle cycles with start=0 → busy=done=round_en=init_state=0, round_idx=0 throughout.
- "abc" block: block_in = 0x61626380 followed by 14 zero words, W15 = 0x00000018; pulse start; no hold →
  - init_state one cycle.
  - round_en on 64 consecutive cycles.
  - t=0: w_t=0x61626380, k_t=0x428a2f98.
  - t=16: w_t=0x61626380.
  - t=17: w_t=0x000F0000.
  - t=63: k_t=0xc67178f2.
  - done exactly one cycle after t=63.
- Full schedule match: same block, all 64 W_t compared against a reference model → zero mismatches.
- Stall insertion: hold=1 for 3 cycles at t=10 and 1 cycle at t=63 → round_idx frozen and round_en=0 during hold; W_t sequence identical to the unstalled run; done 4 cycles later than the unstalled run.
- Start while busy: second start pulse at t=20 with a different block_in → ignored; schedule still matches the first block; no second init_state.
- Reset mid-operation: rst=1 at t=30 → next cycle busy=0, round_idx=0; no done pulse; a following start runs a clean 64-round block.
